oam_dma_ctrl: RTL and testbench
===============================

// Module: oam_dma_ctrl
// PURPOSE
//  CPU-side bus master that sits directly downstream of the 6502 core's bus pins.
//  When idle, it passes CPU address/data/strobes straight through to the system memory bus.
//  A CPU write to the sprite-DMA trigger register halts the CPU by dropping rdy.
//  It then copies one 256-byte CPU page to the PPU OAM data port and returns the bus.
// PARAMETERS
//  ADDR_W     16        bus address width
//  DATA_W     8         bus data width
//  TRIG_ADDR  16'h4014  write here starts DMA; data byte = source page (high address byte)
//  DEST_ADDR  16'h2004  every DMA write goes to this address (OAMDATA)
//  XFER_LEN   256       bytes per transfer; power of two, <= 256
// PORTS
//  clk           in   1       system clock, all state on rising edge
//  b_rst         in   1       reset, asynchronous, active-high (1 = in reset)
//  cpu_addr_out  in   ADDR_W  CPU address
//  cpu_data_out  in   DATA_W  CPU write data
//  ren           in   1       CPU read strobe
//  wen           in   1       CPU write strobe
//  rdy           out  1       CPU ready; 0 halts the CPU
//  bus_addr      out  ADDR_W  system bus address
//  bus_wdata     out  DATA_W  system bus write data
//  bus_ren       out  1       system bus read strobe
//  bus_wen       out  1       system bus write strobe
//  bus_rdata     in   DATA_W  system bus read data; valid the cycle after bus_ren
//  dma_busy      out  1       1 from HALT through the last WRITE
//  dma_done      out  1       one-cycle pulse in the cycle after the last WRITE
// BEHAVIOUR
//  Reset values: state=IDLE, rdy=1, dma_busy=0, dma_done=0, idx=0, page=0, odd=0.
//  Bus outputs pass through from the CPU while in reset.
//  odd: free-running toggle, flips every clk; it is the only alignment reference.
//  IDLE
//   - bus_* = CPU signals, combinational pass-through.
//   - If wen=1 and cpu_addr_out=TRIG_ADDR:
//     - the write still passes to the bus;
//     - page <= cpu_data_out and idx <= 0;
//     - next state is HALT.
//  HALT (1 cycle)
//   - rdy=0, bus_ren=bus_wen=0.
//   - Next state is ALIGN if odd=1, else READ.
//  ALIGN (1 cycle): rdy=0, bus idle; next state is READ.
//  READ
//   - bus_addr={page,idx}, bus_ren=1, bus_wen=0.
//   - Next state is WRITE.
//  WRITE
//   - bus_addr=DEST_ADDR, bus_wen=1, bus_wdata=bus_rdata (combinational).
//   - If idx=XFER_LEN-1: next state is IDLE and dma_done=1 in that next cycle.
//   - Otherwise idx<=idx+1 and next state is READ.
//  In every state other than IDLE: rdy=0, dma_busy=1.
//  CPU ren/wen/addr/data are ignored; a trigger write during DMA is dropped.
//  rdy returns to 1 in the same cycle dma_done pulses.
//  Latency from the trigger-write cycle T:
//   - rdy low from T+1;
//   - total halt = 513 cycles (odd=0 in HALT) or 514 cycles (odd=1 in HALT).
//  idx is log2(XFER_LEN) bits wide and never wraps mid-transfer.
//  Source address increments only in the low byte (page fixed).
//  Async b_rst mid-transfer:
//   - immediate return to IDLE, rdy=1, no dma_done;
//   - partial OAM contents are left as written.
//  Read of TRIG_ADDR in IDLE: pass-through only, no DMA.
// TESTING
//  1) Reset asserted mid-READ.
//     -> rdy=1, dma_busy=0, bus_ren=0 asynchronously.
//     -> After release, CPU traffic passes through unchanged.
//  2) Page $02 holds bytes 0..255; write $02 to $4014 with odd=0 in HALT.
//     -> rdy low exactly 513 cycles.
//     -> 256 writes to $2004 carrying 0..255 in order.
//     -> dma_done pulses once.
//  3) Same as test 2 with odd=1 in HALT.
//     -> one idle ALIGN cycle; rdy low exactly 514 cycles.
//     -> first READ address is $0200.
//  4) CPU drives wen=1, addr=$4014 continuously during DMA.
//     -> no restart; exactly 256 writes.
//     -> idx sequence monotonic, ending at $FF.
//  5) Idle CPU read of $4014 and write of $4015=$AA.
//     -> both pass through unchanged; rdy stays 1; no DMA starts.
//  6) Page $FF.
//     -> source addresses $FF00..$FFFF with no carry into the page.
//     -> last write is followed by IDLE and rdy=1 in the same cycle.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA bus master: passes CPU bus traffic through when idle, and on a write
// to the trigger register halts the CPU and copies one source page into OAMDATA.
module oam_dma_ctrl #(
  parameter int unsigned     ADDR_W    = 16,
  parameter int unsigned     DATA_W    = 8,
  parameter logic [15:0]     TRIG_ADDR = 16'h4014,
  parameter logic [15:0]     DEST_ADDR = 16'h2004,
  parameter int unsigned     XFER_LEN  = 256
) (
  input  logic              clk,
  input  logic              b_rst,
  input  logic [ADDR_W-1:0] cpu_addr_out,
  input  logic [DATA_W-1:0] cpu_data_out,
  input  logic              ren,
  input  logic              wen,
  output logic              rdy,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_ren,
  output logic              bus_wen,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              dma_busy,
  output logic              dma_done
);

  localparam int unsigned IDX_W = (XFER_LEN > 1) ? $clog2(XFER_LEN) : 1;
  localparam int unsigned LO_W  = ADDR_W - DATA_W;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   page_q, page_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                odd_q;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   src_addr;

  // The page stays fixed; only the low byte walks, so no carry can reach the page.
  assign src_addr = {page_q, LO_W'(idx_q)};
  assign dma_done = done_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge b_rst) begin
    if (b_rst) begin
      state_q <= S_IDLE;
      page_q  <= '0;
      idx_q   <= '0;
      odd_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      odd_q   <= ~odd_q;
      done_q  <= done_d;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves a
  // variable unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    rdy       = 1'b0;
    dma_busy  = 1'b1;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_ren   = 1'b0;
    bus_wen   = 1'b0;

    case (state_q)
      S_IDLE: begin
        rdy       = 1'b1;
        dma_busy  = 1'b0;
        bus_addr  = cpu_addr_out;
        bus_wdata = cpu_data_out;
        bus_ren   = ren;
        bus_wen   = wen;
        if (wen && (cpu_addr_out == ADDR_W'(TRIG_ADDR))) begin
          page_d  = cpu_data_out;
          idx_d   = '0;
          state_d = S_HALT;
        end
      end
      S_HALT:  state_d = odd_q ? S_ALIGN : S_READ;
      S_ALIGN: state_d = S_READ;
      S_READ: begin
        bus_addr = src_addr;
        bus_ren  = 1'b1;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        bus_addr  = ADDR_W'(DEST_ADDR);
        bus_wen   = 1'b1;
        bus_wdata = bus_rdata;
        if (idx_q == IDX_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: a memory model feeds reads, and a
// scoreboard of expected source addresses and OAM bytes is consumed as the DUT transfers.
module tb_oam_dma_ctrl;

  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] DEST = 16'h2004;
  localparam int          XFER = 256;

  logic        clk = 1'b0;
  logic        b_rst;
  logic [15:0] cpu_addr_out;
  logic [7:0]  cpu_data_out;
  logic        ren, wen;
  logic        rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_ren, bus_wen;
  logic [7:0]  bus_rdata;
  logic        dma_busy, dma_done;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] rd_q[$];
  logic [7:0]  wd_q[$];
  logic        tb_odd;

  oam_dma_ctrl dut (
    .clk          (clk),
    .b_rst        (b_rst),
    .cpu_addr_out (cpu_addr_out),
    .cpu_data_out (cpu_data_out),
    .ren          (ren),
    .wen          (wen),
    .rdy          (rdy),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_ren      (bus_ren),
    .bus_wen      (bus_wen),
    .bus_rdata    (bus_rdata),
    .dma_busy     (dma_busy),
    .dma_done     (dma_done)
  );

  always #5 clk = ~clk;

  // Memory answers a read strobe with data in the following cycle.
  always @(posedge clk) begin
    if (bus_ren) bus_rdata <= mem[bus_addr];
  end

  // Reference for the alignment toggle: cleared by reset, flips every edge.
  always @(posedge clk or posedge b_rst) begin
    if (b_rst) tb_odd <= 1'b0;
    else       tb_odd <= ~tb_odd;
  end

  task automatic cpu_idle();
    ren = 1'b0; wen = 1'b0; cpu_addr_out = 16'h0000; cpu_data_out = 8'h00;
  endtask

  task automatic test_reset();
    b_rst = 1'b1;
    cpu_addr_out = 16'h1234; cpu_data_out = 8'h5C; ren = 1'b1; wen = 1'b0;
    #1;
    chk_cnt++; if (rdy !== 1'b1) $display("FAIL reset_rdy got=%b want=1", rdy); else pass_cnt++;
    chk_cnt++; if (dma_busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", dma_busy); else pass_cnt++;
    chk_cnt++; if (dma_done !== 1'b0) $display("FAIL reset_done got=%b want=0", dma_done); else pass_cnt++;
    chk_cnt++;
    if ({bus_addr, bus_wdata, bus_ren, bus_wen} !== {16'h1234, 8'h5C, 1'b1, 1'b0})
      $display("FAIL reset_passthru got=%h/%h/%b/%b want=1234/5c/1/0", bus_addr, bus_wdata, bus_ren, bus_wen);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    @(negedge clk); b_rst = 1'b0;
    cpu_idle();
  endtask

  task automatic test_idle_passthru();
    int low;
    @(posedge clk); #1;
    cpu_addr_out = TRIG; ren = 1'b1; wen = 1'b0; cpu_data_out = 8'h33;
    #1;
    chk_cnt++;
    if ({bus_addr, bus_ren, bus_wen} !== {TRIG, 1'b1, 1'b0})
      $display("FAIL idle_read_trig got=%h/%b/%b want=4014/1/0", bus_addr, bus_ren, bus_wen);
    else pass_cnt++;
    @(posedge clk); #1;
    cpu_addr_out = 16'h4015; cpu_data_out = 8'hAA; ren = 1'b0; wen = 1'b1;
    #1;
    chk_cnt++;
    if ({bus_addr, bus_wdata, bus_ren, bus_wen} !== {16'h4015, 8'hAA, 1'b0, 1'b1})
      $display("FAIL idle_write_4015 got=%h/%h/%b/%b want=4015/aa/0/1", bus_addr, bus_wdata, bus_ren, bus_wen);
    else pass_cnt++;
    @(posedge clk); #1;
    cpu_idle();
    low = 0;
    repeat (6) begin
      @(negedge clk);
      if (!rdy || dma_busy) low++;
    end
    chk_cnt++; if (low !== 0) $display("FAIL idle_no_dma got=%0d halted cycles want=0", low); else pass_cnt++;
  endtask

  task automatic run_dma(input logic [7:0] page, input logic want_odd, input bit hammer, input string name);
    int  low_cnt, wr_cnt, done_cnt, quiet_cnt;
    bit  finished;
    logic [15:0] ea;
    logic [7:0]  ed;
    low_cnt = 0; wr_cnt = 0; done_cnt = 0; quiet_cnt = 0; finished = 0;
    rd_q.delete(); wd_q.delete();
    @(posedge clk); #1;
    // Toggle during HALT is the inverse of its value in the trigger cycle.
    if (tb_odd == want_odd) begin @(posedge clk); #1; end
    for (int i = 0; i < XFER; i++) begin
      rd_q.push_back({page, 8'(i)});
      wd_q.push_back(mem[{page, 8'(i)}]);
    end
    ren = 1'b0; wen = 1'b1; cpu_addr_out = TRIG; cpu_data_out = page;
    @(posedge clk); #1;
    if (hammer) cpu_data_out = page ^ 8'h10;
    else        cpu_idle();
    for (int c = 0; c < 600 && !finished; c++) begin
      @(negedge clk);
      if (!rdy) low_cnt++;
      if (!rdy && !bus_ren && !bus_wen) quiet_cnt++;
      if (dma_busy && bus_ren) begin
        chk_cnt++;
        if (rd_q.size() == 0) $display("FAIL %s_extra_read got=%h want=none", name, bus_addr);
        else begin
          ea = rd_q.pop_front();
          if (bus_addr !== ea) $display("FAIL %s_src_addr got=%h want=%h", name, bus_addr, ea);
          else pass_cnt++;
        end
      end
      if (dma_busy && bus_wen) begin
        wr_cnt++;
        chk_cnt++;
        if (wd_q.size() == 0) $display("FAIL %s_extra_write got=%h want=none", name, bus_wdata);
        else begin
          ed = wd_q.pop_front();
          if ({bus_addr, bus_wdata} !== {DEST, ed})
            $display("FAIL %s_oam_write got=%h:%h want=%h:%h", name, bus_addr, bus_wdata, DEST, ed);
          else pass_cnt++;
        end
      end
      if (dma_done) begin
        done_cnt++;
        finished = 1;
        cpu_idle();
        chk_cnt++;
        if ({rdy, dma_busy} !== 2'b10)
          $display("FAIL %s_done_cycle rdy/busy got=%b%b want=10", name, rdy, dma_busy);
        else pass_cnt++;
      end
    end
    repeat (4) begin
      @(negedge clk);
      if (dma_done) done_cnt++;
      if (!rdy) low_cnt++;
    end
    chk_cnt++; if (!finished) $display("FAIL %s_timeout got=no dma_done want=dma_done", name); else pass_cnt++;
    chk_cnt++;
    if (low_cnt !== (want_odd ? 514 : 513))
      $display("FAIL %s_halt_len got=%0d want=%0d", name, low_cnt, want_odd ? 514 : 513);
    else pass_cnt++;
    chk_cnt++; if (wr_cnt !== XFER) $display("FAIL %s_write_cnt got=%0d want=%0d", name, wr_cnt, XFER); else pass_cnt++;
    chk_cnt++; if (done_cnt !== 1) $display("FAIL %s_done_cnt got=%0d want=1", name, done_cnt); else pass_cnt++;
    chk_cnt++;
    if (quiet_cnt !== (want_odd ? 2 : 1))
      $display("FAIL %s_idle_halt_cycles got=%0d want=%0d", name, quiet_cnt, want_odd ? 2 : 1);
    else pass_cnt++;
    chk_cnt++;
    if (rd_q.size() + wd_q.size() !== 0)
      $display("FAIL %s_leftover got=%0d want=0", name, rd_q.size() + wd_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_read();
    bit seen;
    seen = 0;
    @(posedge clk); #1;
    wen = 1'b1; cpu_addr_out = TRIG; cpu_data_out = 8'h05;
    @(posedge clk); #1;
    cpu_idle();
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (dma_busy && bus_ren) seen = 1;
    end
    chk_cnt++; if (!seen) $display("FAIL rst_mid_find_read got=no read want=read"); else pass_cnt++;
    #2 b_rst = 1'b1;
    #1;
    chk_cnt++;
    if ({rdy, dma_busy, bus_ren, dma_done} !== 4'b1000)
      $display("FAIL rst_mid_async rdy/busy/ren/done got=%b%b%b%b want=1000", rdy, dma_busy, bus_ren, dma_done);
    else pass_cnt++;
    cpu_addr_out = 16'h1234; cpu_data_out = 8'h56; wen = 1'b1;
    #1;
    chk_cnt++;
    if ({bus_addr, bus_wdata, bus_wen} !== {16'h1234, 8'h56, 1'b1})
      $display("FAIL rst_mid_passthru got=%h/%h/%b want=1234/56/1", bus_addr, bus_wdata, bus_wen);
    else pass_cnt++;
    @(negedge clk); b_rst = 1'b0;
    cpu_idle();
    @(posedge clk); #1;
    cpu_addr_out = 16'h0BEE; ren = 1'b1;
    #1;
    chk_cnt++;
    if ({bus_addr, bus_ren, bus_wen, rdy, dma_done} !== {16'h0BEE, 1'b1, 1'b0, 1'b1, 1'b0})
      $display("FAIL rst_release_passthru got=%h/%b/%b/%b/%b want=0bee/1/0/1/0",
               bus_addr, bus_ren, bus_wen, rdy, dma_done);
    else pass_cnt++;
    @(posedge clk); #1;
    cpu_addr_out = 16'h0300; cpu_data_out = 8'h9E; ren = 1'b0; wen = 1'b1;
    #1;
    chk_cnt++;
    if ({bus_addr, bus_wdata, bus_wen, dma_busy} !== {16'h0300, 8'h9E, 1'b1, 1'b0})
      $display("FAIL rst_release_write got=%h/%h/%b/%b want=0300/9e/1/0", bus_addr, bus_wdata, bus_wen, dma_busy);
    else pass_cnt++;
    @(posedge clk); #1;
    cpu_idle();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) begin
      mem[{8'h02, 8'(i)}] = 8'(i);
      mem[{8'hFF, 8'(i)}] = 8'(i) ^ 8'hA5;
    end
    bus_rdata = 8'h00;
    test_reset();
    test_idle_passthru();
    run_dma(8'h02, 1'b0, 1'b0, "even");
    run_dma(8'h02, 1'b1, 1'b0, "odd");
    run_dma(8'h03, 1'b0, 1'b1, "hammer");
    run_dma(8'hFF, 1'b1, 1'b0, "pageff");
    test_reset_mid_read();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
